branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
IF-stage branch predictor: a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters. It supplies the next-PC guess every cycle and is trained at branch resolution in the MEM stage. It raises a mispredict/correction request, which the hazard control unit consumes to select the redirect PC and flush IF/ID, ID/EX and EX/MEM. Signals are grouped in branch_predictor_if (modports bp and tb).

Parameters:
BTB_ENTRIES, 16, number of BTB entries; must be a power of two, 2..256.
IDX_W, $clog2(BTB_ENTRIES), index width; derived, not overridden.

Ports:
CLK  input  1  system clock, rising edge.
nRST  input  1  asynchronous active-low reset.
IFpc  input  32  PC of the instruction being fetched.
predtaken  output  1  IF prediction: branch taken.
predtarget  output  32  predicted next PC: BTB target if predtaken, else IFpc+4.
MMbranch  input  1  instruction in MEM is a BEQ/BNE.
MMupdate  input  1  EX/MEM → MEM/WB advance enable (hazard unit MMWBEN); qualifies training.
MMpc  input  32  PC of the MEM-stage branch.
MMtaken  input  1  resolved outcome (from MMequal and opcode).
MMtarget  input  32  resolved branch target.
MMpredtaken  input  1  prediction carried down the pipe with this branch.
MMpredtarget  input  32  predicted target carried down the pipe.
mispredict  output  1  redirect required.
correctpc  output  32  redirect PC.
brcount  output  32  resolved branches since reset.
misscount  output  32  mispredicts since reset.

Behaviour:
- Address split: idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Entry fields: valid, tag, target[31:0], ctr[1:0].
- Reset (async, nRST=0): all valid=0, ctr=2'b01, targets/tags=0, brcount=0, misscount=0. Outputs during reset: predtaken=0, predtarget=IFpc+4, mispredict=0.
- Lookup is combinational, 0-cycle latency: hit = valid[idx] && tag match; predtaken = hit && ctr[idx][1].
- mispredict is combinational = MMbranch && (MMtaken != MMpredtaken || (MMtaken && MMtarget != MMpredtarget)).
- correctpc = MMtaken ? MMtarget : MMpc+4. It is driven regardless of mispredict.
- Training happens only on rising CLK when MMbranch && MMupdate. A stalled MEM stage does not double-train.
  - Hit, taken: ctr saturating increment (max 11); target overwritten with MMtarget.
  - Hit, not taken: ctr saturating decrement (min 00).
  - Miss, taken: allocate/replace entry; valid=1, tag, target, ctr=2'b10.
  - Miss, not taken: no change.
- Counters (same qualifier as training):
  - brcount increments by 1.
  - misscount increments by 1 when mispredict is also 1.
  - Both saturate at 32'hFFFF_FFFF, with no wrap.
- Same-cycle lookup and update to the same index: lookup returns pre-update state; the new state is visible the following cycle.
- Aliasing: different PCs sharing an index replace each other. Tag compare prevents a false hit.
- Reset asserted mid-training: reset wins; the entry is cleared.
- Pure combinational outputs have no state machine. Sequential state is the BTB array plus two statistic counters.

Decomposition:
- Add to cpu_types_pkg / new branch_predictor_types_pkg:
  - typedef ctr_t (logic [1:0]) with constants STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11.
  - btb_entry_t packed struct {valid, tag, target, ctr}.
- One sub-module: sat_counter2 (2-bit saturating up/down, pure function or tiny combinational block). The BTB array stays in the top.

Test Plan:
- Reset: nRST=0 then 1; IFpc=32'h100 → predtaken=0, predtarget=32'h104, brcount=0, misscount=0.
- Cold taken branch: MMbranch=1, MMupdate=1, MMpc=32'h40, MMtaken=1, MMtarget=32'h80, MMpredtaken=0 → mispredict=1, correctpc=32'h80. Next cycle IFpc=32'h40 → predtaken=1, predtarget=32'h80; misscount=1.
- Counter saturation: train PC 32'h40 taken 4×, then not-taken 1× → still predtaken=1 (ctr 11→10). One more not-taken → predtaken=0.
- Stall gating: MMbranch=1, MMupdate=0 held 3 cycles → no BTB change, brcount unchanged. mispredict still reflects inputs.
- Aliasing (16 entries): train 32'h40 taken, then 32'h440 taken target 32'h900 → IFpc=32'h40 predtaken=0; IFpc=32'h440 predtarget=32'h900.
- Target mismatch: MMpredtaken=1, MMpredtarget=32'h80, MMtaken=1, MMtarget=32'h84 → mispredict=1, correctpc=32'h84. Not-taken fall-through: MMpc=32'h40, MMtaken=0, MMpredtaken=1 → correctpc=32'h44.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared types for the BTB branch predictor
package branch_predictor_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t STRONG_NT = 2'b00;
    localparam ctr_t WEAK_NT   = 2'b01;
    localparam ctr_t WEAK_T    = 2'b10;
    localparam ctr_t STRONG_T  = 2'b11;

    // Tag field is sized for the smallest index; unused upper bits stay zero.
    localparam int TAG_W = 30;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        ctr_t             ctr;
    } btb_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// rtl/branch_predictor_sat_counter2.sv - 2-bit saturating up/down counter step
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_t cur,
    input  logic up,
    output ctr_t nxt
);

    always_comb begin
        nxt = cur;
        if (up) begin
            if (cur != STRONG_T) nxt = cur + 2'd1;
        end else begin
            if (cur != STRONG_NT) nxt = cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, trained in MEM
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] IFpc,
    output logic        predtaken,
    output logic [31:0] predtarget,
    input  logic        MMbranch,
    input  logic        MMupdate,
    input  logic [31:0] MMpc,
    input  logic        MMtaken,
    input  logic [31:0] MMtarget,
    input  logic        MMpredtaken,
    input  logic [31:0] MMpredtarget,
    output logic        mispredict,
    output logic [31:0] correctpc,
    output logic [31:0] brcount,
    output logic [31:0] misscount
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);

    btb_entry_t btb [BTB_ENTRIES];

    logic [IDX_W-1:0] if_idx, mm_idx;
    logic [TAG_W-1:0] if_tag, mm_tag;
    btb_entry_t       if_ent, mm_ent;
    logic             if_hit, mm_hit, train;
    ctr_t             mm_ctr_nxt;
    logic             unused_pc_lsbs;

    assign unused_pc_lsbs = ^{IFpc[1:0], MMpc[1:0]};

    assign if_idx = IFpc[IDX_W+1:2];
    assign mm_idx = MMpc[IDX_W+1:2];
    assign if_tag = TAG_W'(IFpc[31:IDX_W+2]);
    assign mm_tag = TAG_W'(MMpc[31:IDX_W+2]);

    assign if_ent = btb[if_idx];
    assign mm_ent = btb[mm_idx];
    assign if_hit = if_ent.valid && (if_ent.tag == if_tag);
    assign mm_hit = mm_ent.valid && (mm_ent.tag == mm_tag);

    assign predtaken  = if_hit && if_ent.ctr[1];
    assign predtarget = predtaken ? if_ent.target : IFpc + 32'd4;

    // Held low during reset so the hazard unit never redirects out of reset.
    assign mispredict = nRST && MMbranch &&
                        ((MMtaken != MMpredtaken) || (MMtaken && (MMtarget != MMpredtarget)));
    assign correctpc  = MMtaken ? MMtarget : MMpc + 32'd4;

    assign train = MMbranch && MMupdate;

    sat_counter2 u_ctr (
        .cur (mm_ent.ctr),
        .up  (MMtaken),
        .nxt (mm_ctr_nxt)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
            end
        end else if (train) begin
            if (mm_hit) begin
                btb[mm_idx].ctr <= mm_ctr_nxt;
                if (MMtaken) btb[mm_idx].target <= MMtarget;
            end else if (MMtaken) begin
                btb[mm_idx] <= '{valid: 1'b1, tag: mm_tag, target: MMtarget, ctr: WEAK_T};
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            brcount   <= '0;
            misscount <= '0;
        end else if (train) begin
            if (brcount != '1) brcount <= brcount + 32'd1;
            if (mispredict && (misscount != '1)) misscount <= misscount + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed vector bench for branch_predictor
module tb_branch_predictor;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] IFpc;
    logic        predtaken;
    logic [31:0] predtarget;
    logic        MMbranch, MMupdate, MMtaken, MMpredtaken;
    logic [31:0] MMpc, MMtarget, MMpredtarget;
    logic        mispredict;
    logic [31:0] correctpc, brcount, misscount;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    branch_predictor #(.BTB_ENTRIES(16)) dut (
        .CLK(CLK), .nRST(nRST), .IFpc(IFpc),
        .predtaken(predtaken), .predtarget(predtarget),
        .MMbranch(MMbranch), .MMupdate(MMupdate), .MMpc(MMpc),
        .MMtaken(MMtaken), .MMtarget(MMtarget),
        .MMpredtaken(MMpredtaken), .MMpredtarget(MMpredtarget),
        .mispredict(mispredict), .correctpc(correctpc),
        .brcount(brcount), .misscount(misscount)
    );

    typedef struct {
        logic [31:0] ifpc;
        logic        br;
        logic        upd;
        logic [31:0] mmpc;
        logic        tk;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        e_ptk;
        logic [31:0] e_ptgt;
        logic        e_mis;
        logic [31:0] e_cpc;
        logic [31:0] e_bc;
        logic [31:0] e_mc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        IFpc = v.ifpc; MMbranch = v.br; MMupdate = v.upd; MMpc = v.mmpc;
        MMtaken = v.tk; MMtarget = v.tgt; MMpredtaken = v.ptk; MMpredtarget = v.ptgt;
    endtask

    initial begin
        // ifpc, br, upd, mmpc, tk, tgt, ptk, ptgt | e_ptk, e_ptgt, e_mis, e_cpc, e_bc, e_mc
        vecs.push_back('{'h40, 1, 1, 'h40, 1, 'h80, 0, 'h0,  0, 'h44, 1, 'h80, 0, 0}); // cold taken
        vecs.push_back('{'h40, 0, 0, 'h0,  0, 'h0,  0, 'h0,  1, 'h80, 0, 'h4,  1, 1});
        vecs.push_back('{'h40, 1, 1, 'h40, 1, 'h80, 1, 'h80, 1, 'h80, 0, 'h80, 1, 1});
        vecs.push_back('{'h40, 1, 1, 'h40, 1, 'h80, 1, 'h80, 1, 'h80, 0, 'h80, 2, 1});
        vecs.push_back('{'h40, 1, 1, 'h40, 1, 'h80, 1, 'h80, 1, 'h80, 0, 'h80, 3, 1});
        vecs.push_back('{'h40, 1, 1, 'h40, 0, 'h80, 1, 'h80, 1, 'h80, 1, 'h44, 4, 1}); // 11 -> 10
        vecs.push_back('{'h40, 0, 0, 'h0,  0, 'h0,  0, 'h0,  1, 'h80, 0, 'h4,  5, 2});
        vecs.push_back('{'h40, 1, 1, 'h40, 0, 'h80, 1, 'h80, 1, 'h80, 1, 'h44, 5, 2}); // 10 -> 01
        vecs.push_back('{'h40, 0, 0, 'h0,  0, 'h0,  0, 'h0,  0, 'h44, 0, 'h4,  6, 3});
        for (int i = 0; i < 3; i++)                                                    // stalled MEM
            vecs.push_back('{'h40, 1, 0, 'h40, 1, 'h80, 0, 'h0, 0, 'h44, 1, 'h80, 6, 3});
        vecs.push_back('{'h40, 0, 0, 'h0,  0, 'h0,  0, 'h0,  0, 'h44, 0, 'h4,  6, 3});
        vecs.push_back('{'h40, 1, 1, 'h40, 1, 'h88, 0, 'h0,  0, 'h44, 1, 'h88, 6, 3}); // same-cycle
        vecs.push_back('{'h40, 0, 0, 'h0,  0, 'h0,  0, 'h0,  1, 'h88, 0, 'h4,  7, 4});
        vecs.push_back('{'h440, 1, 1, 'h440, 1, 'h900, 0, 'h0, 0, 'h444, 1, 'h900, 7, 4}); // alias
        vecs.push_back('{'h40, 0, 0, 'h0,  0, 'h0,  0, 'h0,  0, 'h44, 0, 'h4,  8, 5});
        vecs.push_back('{'h440, 0, 0, 'h0, 0, 'h0,  0, 'h0,  1, 'h900, 0, 'h4, 8, 5});
        vecs.push_back('{'h100, 1, 0, 'h40, 1, 'h84, 1, 'h80, 0, 'h104, 1, 'h84, 8, 5}); // target mismatch
        vecs.push_back('{'h100, 1, 0, 'h40, 0, 'h80, 1, 'h80, 0, 'h104, 1, 'h44, 8, 5}); // fall-through
        vecs.push_back('{'h100, 1, 0, 'h40, 0, 'h80, 0, 'h0,  0, 'h104, 0, 'h44, 8, 5});
        vecs.push_back('{'h100, 1, 0, 'h40, 1, 'h80, 1, 'h80, 0, 'h104, 0, 'h80, 8, 5});
        vecs.push_back('{'h100, 0, 0, 'h40, 1, 'h84, 0, 'h80, 0, 'h104, 0, 'h84, 8, 5}); // not a branch
        vecs.push_back('{'h848, 1, 1, 'h848, 0, 'h0, 0, 'h0, 0, 'h84c, 0, 'h84c, 8, 5}); // miss, not taken
        vecs.push_back('{'h848, 0, 0, 'h0, 0, 'h0,  0, 'h0,  0, 'h84c, 0, 'h4,  9, 5});

        nRST = 1'b0;
        drive('{'h100, 1, 1, 'h40, 1, 'h80, 0, 'h0, 0, 0, 0, 0, 0, 0});
        #12;
        chk("rst_mispredict", -1, 32'(mispredict), 32'd0);
        chk("rst_predtaken", -1, 32'(predtaken), 32'd0);
        chk("rst_predtarget", -1, predtarget, 32'h104);
        @(negedge CLK);
        nRST = 1'b1;
        MMbranch = 1'b0; MMupdate = 1'b0;
        #1;
        chk("rst_brcount", -1, brcount, 32'd0);
        chk("rst_misscount", -1, misscount, 32'd0);

        foreach (vecs[r]) begin
            @(negedge CLK);
            drive(vecs[r]);
            #1;
            chk("predtaken", r, 32'(predtaken), 32'(vecs[r].e_ptk));
            chk("predtarget", r, predtarget, vecs[r].e_ptgt);
            chk("mispredict", r, 32'(mispredict), 32'(vecs[r].e_mis));
            chk("correctpc", r, correctpc, vecs[r].e_cpc);
            chk("brcount", r, brcount, vecs[r].e_bc);
            chk("misscount", r, misscount, vecs[r].e_mc);
        end

        // Reset asserted while a training cycle is pending: entry must be cleared.
        @(negedge CLK);
        drive('{'h440, 1, 1, 'h440, 1, 'h900, 1, 'h900, 0, 0, 0, 0, 0, 0});
        #1;
        chk("pre_rst_predtaken", -2, 32'(predtaken), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("midrst_predtaken", -2, 32'(predtaken), 32'd0);
        chk("midrst_mispredict", -2, 32'(mispredict), 32'd0);
        chk("midrst_brcount", -2, brcount, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        MMbranch = 1'b0; MMupdate = 1'b0;
        nRST = 1'b1;
        #1;
        chk("post_rst_predtaken", -2, 32'(predtaken), 32'd0);
        chk("post_rst_predtarget", -2, predtarget, 32'h444);
        chk("post_rst_misscount", -2, misscount, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
